// File: rtl/axi4_write_arbiter.sv
// Round-robin arbiter sharing one AXI4 write path (AW/W/B) between NUM_REQ burst masters.
// Optional WLAST consistency checking is enabled by defining ARB_WLAST_CHECK_EN.
module axi4_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [NUM_REQ*ADDR_W-1:0]   M_AWADDR,
  input  logic [NUM_REQ*8-1:0]        M_AWLEN,
  input  logic [NUM_REQ-1:0]          M_AWVALID,
  output logic [NUM_REQ-1:0]          M_AWREADY,
  input  logic [NUM_REQ*DATA_W-1:0]   M_WDATA,
  input  logic [NUM_REQ-1:0]          M_WLAST,
  input  logic [NUM_REQ-1:0]          M_WVALID,
  output logic [NUM_REQ-1:0]          M_WREADY,
  output logic [NUM_REQ-1:0]          M_BVALID,
  input  logic [NUM_REQ-1:0]          M_BREADY,
  output logic [ADDR_W-1:0]           S_AWADDR,
  output logic [7:0]                  S_AWLEN,
  output logic                        S_AWVALID,
  input  logic                        S_AWREADY,
  output logic [DATA_W-1:0]           S_WDATA,
  output logic                        S_WLAST,
  output logic                        S_WVALID,
  input  logic                        S_WREADY,
  input  logic                        S_BVALID,
  output logic                        S_BREADY,
  output logic [NUM_REQ-1:0]          GRANT,
  output logic                        BUSY
`ifdef ARB_WLAST_CHECK_EN
  ,
  output logic                        ERR_WLAST
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [7:0]         beat_q, beat_d;
  logic [7:0]         len_q, len_d;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic               aw_hs, w_hs, b_hs, wlast_int;

  assign wlast_int = (beat_q == len_q);
  assign aw_hs     = (state_q == ADDR) && S_AWVALID && S_AWREADY;
  assign w_hs      = (state_q == DATA) && S_WVALID && S_WREADY;
  assign b_hs      = (state_q == RESP) && S_BVALID && S_BREADY;
  assign GRANT     = grant_q;
  assign BUSY      = (state_q != IDLE);

  // Scan upward from the requester after the previous owner, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!pick_found && M_AWVALID[(int'(last_q) + i) % NUM_REQ]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'((int'(last_q) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    S_AWADDR  = '0;
    S_AWLEN   = '0;
    S_AWVALID = 1'b0;
    S_WDATA   = '0;
    S_WLAST   = 1'b0;
    S_WVALID  = 1'b0;
    S_BREADY  = 1'b0;
    M_AWREADY = '0;
    M_WREADY  = '0;
    M_BVALID  = '0;
    case (state_q)
      ADDR: begin
        S_AWADDR  = M_AWADDR[gidx_q*ADDR_W +: ADDR_W];
        S_AWLEN   = M_AWLEN[gidx_q*8 +: 8];
        S_AWVALID = M_AWVALID[gidx_q];
        M_AWREADY = grant_q & {NUM_REQ{S_AWREADY}};
      end
      DATA: begin
        S_WDATA  = M_WDATA[gidx_q*DATA_W +: DATA_W];
        S_WLAST  = wlast_int;
        S_WVALID = M_WVALID[gidx_q];
        M_WREADY = grant_q & {NUM_REQ{S_WREADY}};
      end
      RESP: begin
        S_BREADY = M_BREADY[gidx_q];
        M_BVALID = grant_q & {NUM_REQ{S_BVALID}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    beat_d  = beat_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gidx_d            = pick_idx;
          state_d           = ADDR;
        end
      end
      ADDR: begin
        if (aw_hs) begin
          beat_d  = '0;
          len_d   = M_AWLEN[gidx_q*8 +: 8];
          state_d = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          beat_d = beat_q + 8'd1;
          if (wlast_int) state_d = RESP;
        end
      end
      RESP: begin
        if (b_hs) begin
          last_d  = gidx_q;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      beat_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
    end
  end

`ifdef ARB_WLAST_CHECK_EN
  logic err_q, err_d;

  // Sticky: any accepted beat whose requester WLAST disagrees with the counter.
  always_comb begin
    err_d = err_q;
    if (w_hs && (M_WLAST[gidx_q] != wlast_int)) err_d = 1'b1;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign ERR_WLAST = err_q;
`else
  logic unused_wlast;
  assign unused_wlast = ^M_WLAST;
`endif

endmodule
